// File: rtl/decim3_frame_packer_if.sv
// Sample-stream and frame-output bundle for decim3_frame_packer.
// The master side drives the fast-rate stream; the slave side is the packer.
interface decim3_frame_packer_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 enb;
    logic                 enb_1_3_1;
    logic [DATA_W-1:0]    din;
    logic                 err_clr;
    logic [DATA_W-1:0]    dout_0;
    logic [DATA_W-1:0]    dout_1;
    logic [DATA_W-1:0]    dout_2;
    logic                 dout_valid;
    logic [1:0]           slot;
    logic                 phase_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output enb, enb_1_3_1, din, err_clr,
        input  dout_0, dout_1, dout_2, dout_valid, slot, phase_err, err_cnt
    );

    modport slave (
        input  enb, enb_1_3_1, din, err_clr,
        output dout_0, dout_1, dout_2, dout_valid, slot, phase_err, err_cnt
    );
endinterface

// File: rtl/decim3_frame_packer.sv
// Packs three enb-qualified samples into one frame for the 1/3-rate section and
// monitors the slow enable for phase alignment against the sample stream.
module decim3_frame_packer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    decim3_frame_packer_if.slave bus
);
    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    logic [1:0]           slot_q, slot_d, slot_eff;
    logic [DATA_W-1:0]    s0_q, s0_d, s1_q, s1_d;
    logic [DATA_W-1:0]    dout_0_q, dout_0_d, dout_1_q, dout_1_d, dout_2_q, dout_2_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 phase_err_q, phase_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_event;

    // Slow enable forces the sample into slot 0, which also resyncs a misaligned stream.
    assign slot_eff = bus.enb_1_3_1 ? 2'd0 : slot_q;

    // Error sources: orphan or misplaced slow enable, or slot-0 sample without one.
    assign err_event = bus.enb_1_3_1 ? (!bus.enb || (slot_q != 2'd0))
                                     : (bus.enb && (slot_q == 2'd0));

    always_comb begin
        slot_d       = slot_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        dout_0_d     = dout_0_q;
        dout_1_d     = dout_1_q;
        dout_2_d     = dout_2_q;
        dout_valid_d = 1'b0;
        if (bus.enb) begin
            case (slot_eff)
                2'd0:    s0_d = bus.din;
                2'd1:    s1_d = bus.din;
                default: begin
                    dout_0_d     = s0_q;
                    dout_1_d     = s1_q;
                    dout_2_d     = bus.din;
                    dout_valid_d = 1'b1;
                end
            endcase
            slot_d = (slot_eff == 2'd2) ? 2'd0 : slot_eff + 2'd1;
        end
    end

    // An error event in the same cycle as err_clr restarts the count at one.
    always_comb begin
        phase_err_d = phase_err_q;
        err_cnt_d   = err_cnt_q;
        if (err_event) begin
            phase_err_d = 1'b1;
            if (bus.err_clr) begin
                err_cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (err_cnt_q != CntMax) begin
                err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (bus.err_clr) begin
            phase_err_d = 1'b0;
            err_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q       <= 2'd0;
            s0_q         <= '0;
            s1_q         <= '0;
            dout_0_q     <= '0;
            dout_1_q     <= '0;
            dout_2_q     <= '0;
            dout_valid_q <= 1'b0;
            phase_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            slot_q       <= slot_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            dout_0_q     <= dout_0_d;
            dout_1_q     <= dout_1_d;
            dout_2_q     <= dout_2_d;
            dout_valid_q <= dout_valid_d;
            phase_err_q  <= phase_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.dout_0     = dout_0_q;
    assign bus.dout_1     = dout_1_q;
    assign bus.dout_2     = dout_2_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.slot       = slot_q;
    assign bus.phase_err  = phase_err_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule
